// File: rtl/vx_mem_line_splitter.sv
// ---------------------------------------------------------------------------
// vx_mem_line_splitter
//
// Splits one cache-line-wide VX memory request into a series of 32-bit word
// requests, with at most one word outstanding. Reads collect the returned
// words into one line response. Writes send only words with a nonzero byte
// enable and produce no response. This lets wide-line caches share a 32-bit
// OBI bus through the downstream VX-to-OBI bridge.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   line_req_*          upstream line request (valid/ready, rw, byteen,
//                       addr, data, tag)
//   line_rsp_*          upstream line read response (valid/ready, data, tag)
//   word_req_*          downstream word request (valid/ready, rw, byteen,
//                       byte addr, data, tag = word index)
//   word_rsp_*          downstream word read response (valid/ready, data,
//                       tag; the response tag is not inspected)
//
// Every output is decoded from the state and registers only. No input has a
// combinational path to an output.
// ---------------------------------------------------------------------------
module vx_mem_line_splitter #(
   parameter int LINE_WIDTH_BIT = 128,
   parameter int LINE_ADDR_BIT  = 26,
   parameter int TAG_WIDTH_BIT  = 1
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  line_req_valid_i,
   output logic                                  line_req_ready_o,
   input  logic                                  line_req_rw_i,
   input  logic [LINE_WIDTH_BIT/8-1:0]           line_req_byteen_i,
   input  logic [LINE_ADDR_BIT-1:0]              line_req_addr_i,
   input  logic [LINE_WIDTH_BIT-1:0]             line_req_data_i,
   input  logic [TAG_WIDTH_BIT-1:0]              line_req_tag_i,
   output logic                                  line_rsp_valid_o,
   input  logic                                  line_rsp_ready_i,
   output logic [LINE_WIDTH_BIT-1:0]             line_rsp_data_o,
   output logic [TAG_WIDTH_BIT-1:0]              line_rsp_tag_o,
   output logic                                  word_req_valid_o,
   input  logic                                  word_req_ready_i,
   output logic                                  word_req_rw_o,
   output logic [3:0]                            word_req_byteen_o,
   output logic [31:0]                           word_req_addr_o,
   output logic [31:0]                           word_req_data_o,
   output logic [$clog2(LINE_WIDTH_BIT/32)-1:0]  word_req_tag_o,
   input  logic                                  word_rsp_valid_i,
   output logic                                  word_rsp_ready_o,
   input  logic [31:0]                           word_rsp_data_i,
   input  logic [$clog2(LINE_WIDTH_BIT/32)-1:0]  word_rsp_tag_i
);

   localparam int N            = LINE_WIDTH_BIT / 32;
   localparam int WORD_IDX_BIT = $clog2(N);
   localparam int BYTEEN_BIT   = LINE_WIDTH_BIT / 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND_REQ = 2'd1,
      WAIT_RSP = 2'd2,
      LINE_RSP = 2'd3
   } state_t;

   typedef struct packed {
      logic                    found;
      logic [WORD_IDX_BIT-1:0] idx;
   } pick_t;

   // Lowest word at or above 'start' that has any byte enable set.
   function automatic pick_t pick_word(input logic [BYTEEN_BIT-1:0] be,
                                       input int start);
      pick_t p;
      p = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if ((|be[4*i +: 4]) && (i >= start)) begin
            p.found = 1'b1;
            p.idx   = WORD_IDX_BIT'(i);
         end
      end
      return p;
   endfunction

   state_t                    state_q;
   logic [WORD_IDX_BIT-1:0]   cnt_q;
   logic                      rw_q;
   logic [BYTEEN_BIT-1:0]     byteen_q;
   logic [LINE_ADDR_BIT-1:0]  addr_q;
   logic [LINE_WIDTH_BIT-1:0] data_q;
   logic [TAG_WIDTH_BIT-1:0]  tag_q;
   logic [LINE_WIDTH_BIT-1:0] buf_q;

   pick_t first_pick;
   pick_t next_pick;

   assign first_pick = pick_word(line_req_byteen_i, 0);
   assign next_pick  = pick_word(byteen_q, int'(cnt_q) + 1);

   // The downstream response tag exists only for interface compatibility.
   logic unused_rsp_tag;
   assign unused_rsp_tag = ^word_rsp_tag_i;

   // NOTE: sequential state is updated only with non-blocking assignments so
   // every register samples the values from before the clock edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the read buffer is reset too, so a line aborted by reset
         // cannot leave stale words visible on line_rsp_data_o.
         state_q  <= IDLE;
         cnt_q    <= '0;
         rw_q     <= 1'b0;
         byteen_q <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         tag_q    <= '0;
         buf_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (line_req_valid_i) begin
                  rw_q     <= line_req_rw_i;
                  byteen_q <= line_req_byteen_i;
                  addr_q   <= line_req_addr_i;
                  data_q   <= line_req_data_i;
                  tag_q    <= line_req_tag_i;
                  if (!line_req_rw_i) begin
                     cnt_q   <= '0;
                     state_q <= SEND_REQ;
                  end else if (first_pick.found) begin
                     cnt_q   <= first_pick.idx;
                     state_q <= SEND_REQ;
                  end
                  // A write with no enabled byte is accepted and dropped.
               end
            end
            SEND_REQ: begin
               if (word_req_ready_i) begin
                  if (!rw_q) begin
                     state_q <= WAIT_RSP;
                  end else if (next_pick.found) begin
                     cnt_q <= next_pick.idx;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            WAIT_RSP: begin
               if (word_rsp_valid_i) begin
                  buf_q[32*cnt_q +: 32] <= word_rsp_data_i;
                  if (cnt_q == WORD_IDX_BIT'(N - 1)) begin
                     state_q <= LINE_RSP;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                     state_q <= SEND_REQ;
                  end
               end
            end
            LINE_RSP: begin
               if (line_rsp_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign line_req_ready_o  = (state_q == IDLE);
   assign word_req_valid_o  = (state_q == SEND_REQ);
   assign word_rsp_ready_o  = (state_q == WAIT_RSP);
   assign line_rsp_valid_o  = (state_q == LINE_RSP);

   assign word_req_rw_o     = rw_q;
   assign word_req_byteen_o = rw_q ? byteen_q[4*cnt_q +: 4] : 4'hF;
   assign word_req_addr_o   = 32'({addr_q, cnt_q, 2'b00});
   assign word_req_data_o   = data_q[32*cnt_q +: 32];
   assign word_req_tag_o    = cnt_q;

   assign line_rsp_data_o   = buf_q;
   assign line_rsp_tag_o    = tag_q;

endmodule

// File: doc/vx_mem_line_splitter.md
Name: vx_mem_line_splitter

Overview:
- Sits directly upstream of the VX-memory-to-OBI bridge.
- Accepts one cache-line-wide VX memory request and splits it into a sequence of 32-bit word requests with at most one outstanding.
- For reads, it reassembles the returned words into a single line response.
- This lets wide-line caches share the 32-bit OBI bus.

Parameters:
- LINE_WIDTH_BIT, 128: line width; must be a multiple of 32 and at least 64.
- LINE_ADDR_BIT, 26: line address width. Constraint: LINE_ADDR_BIT + log2(N) + 2 <= 32.
- TAG_WIDTH_BIT, 1: upstream tag width.
- Derived: N = LINE_WIDTH_BIT/32; WORD_IDX_BIT = $clog2(N).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- line_req_valid_i  in  1  line request valid
- line_req_ready_o  out  1  line request ready
- line_req_rw_i  in  1  1=write, 0=read
- line_req_byteen_i  in  LINE_WIDTH_BIT/8  byte enables
- line_req_addr_i  in  LINE_ADDR_BIT  line address
- line_req_data_i  in  LINE_WIDTH_BIT  write data
- line_req_tag_i  in  TAG_WIDTH_BIT  request tag
- line_rsp_valid_o  out  1  line read response valid
- line_rsp_ready_i  in  1  line response ready
- line_rsp_data_o  out  LINE_WIDTH_BIT  assembled read data
- line_rsp_tag_o  out  TAG_WIDTH_BIT  tag of the request
- word_req_valid_o  out  1  word request valid
- word_req_ready_i  in  1  word request ready
- word_req_rw_o  out  1  latched rw
- word_req_byteen_o  out  4  word byte enables
- word_req_addr_o  out  32  byte address
- word_req_data_o  out  32  word write data
- word_req_tag_o  out  WORD_IDX_BIT  current word index
- word_rsp_valid_i  in  1  word read response valid
- word_rsp_ready_o  out  1  word response ready
- word_rsp_data_i  in  32  word read data
- word_rsp_tag_i  in  WORD_IDX_BIT  not inspected; interface compatibility only

Behaviour:
- Reset:
  - All registers clear to 0: state=IDLE, counter, latched request, read buffer.
  - Outputs after reset: line_req_ready_o=1; all other valid/ready outputs=0; data/addr/tag outputs=0.
- Outputs are decoded from state and registers only; there are no combinational paths from inputs to outputs.
- Word mapping for index i:
  - word_req_addr_o = {line_addr, i[WORD_IDX_BIT-1:0], 2'b00}, zero-extended to 32 bits.
  - word_req_data_o = data[32*i +: 32].
  - Write byteen = byteen[4*i +: 4]; read byteen = 4'hF.
  - Word 0 occupies the LSBs.
- FSM states: IDLE, SEND_REQ, WAIT_RSP, LINE_RSP.
- IDLE:
  - line_req_ready_o=1.
  - On a valid line request: latch rw/byteen/addr/data/tag.
  - Read: counter=0 -> SEND_REQ.
  - Write: counter = lowest word with nonzero byteen -> SEND_REQ. If no word has nonzero byteen, the request is accepted, dropped, and the FSM stays in IDLE.
- SEND_REQ:
  - word_req_valid_o=1.
  - On word_req_ready_i, read: -> WAIT_RSP.
  - On word_req_ready_i, write: counter = next higher word with nonzero byteen -> SEND_REQ. If none remains -> IDLE.
  - Writes never receive a downstream response and never produce a line response.
- WAIT_RSP:
  - word_rsp_ready_o=1.
  - On word_rsp_valid_i: store data into buffer slot[counter].
  - If counter==N-1 -> LINE_RSP; else counter+1 -> SEND_REQ.
- LINE_RSP:
  - line_rsp_valid_o=1, with data and tag held stable.
  - On line_rsp_ready_i -> IDLE.
- Outside WAIT_RSP, word_rsp_ready_o=0 and word_rsp_valid_i is ignored.
- Latency with zero-wait downstream:
  - Read: accepted at cycle 0; word requests at cycles 1,3,…,2N-1; line_rsp_valid_o at cycle 2N+1.
  - Write with k enabled words: one word per cycle, back in IDLE at cycle k+1.
- Reset asserted mid-operation aborts immediately to IDLE. The partial line is discarded, and no response is produced.

Test Plan:
- Read, N=4, addr=0x10, tag=1; responder returns 0xA0..0xA3 with 0 wait.
  - Word addrs 0x100, 0x104, 0x108, 0x10C with byteen F.
  - line_rsp_data_o=0x000000A3_000000A2_000000A1_000000A0, tag=1, valid at cycle 9.
- Full write, byteen=16'hFFFF, addr=0x2, with word_req_ready_i stalled 3 cycles on word 2.
  - Four word requests at 0x20..0x2C; correct data slices held stable during the stall.
  - No line response; line_req_ready_o returns high after the last handshake.
- Sparse write, byteen=16'h00F0.
  - Exactly one word request: addr offset +4, byteen F, data[63:32].
- Zero byteen write.
  - Accepted in one cycle; no word_req_valid_o ever asserted; a new request is accepted the next cycle.
- Read with line_rsp_ready_i low for 5 cycles.
  - line_rsp_valid_o and data stay stable; line_req_ready_o stays 0 until the response handshake.
- rst_ni pulsed low while in WAIT_RSP after 2 words.
  - All valids drop asynchronously; line_req_ready_o=1.
  - Next read completes correctly; none of the stale buffer contents appear.
